move_button_conditioner: RTL

- Upstream front end for the TicTacToe game core.
- Takes raw asynchronous pushbutton levels (board buttons for sel and next) and synchronizes and debounces each one.
- Emits a single-cycle press pulse per physical press, so the game core advances exactly one step per press.
- Also provides the debounced level and a release pulse per button.

---
 rtl/tictactoe_pkg.sv | 26 ++
 rtl/btn_debounce_ch.sv | 185 ++++++++++++++++++
 rtl/move_button_conditioner.sv | 64 ++++++
 3 files changed

// File: rtl/tictactoe_pkg.sv
// ============================================================================
// Module      : tictactoe_pkg
// Description : Shared types and constants for the TicTacToe front end and
//               game core. It holds the debounce channel state enum and the
//               channel index of each board button.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tictactoe_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        HELD_HI = 2'd2,
        WAIT_LO = 2'd3
    } btn_state_t;

    // Channel indices used by the game core.
    localparam int BTN_SEL  = 0;
    localparam int BTN_NEXT = 1;

endpackage : tictactoe_pkg

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// Module      : btn_debounce_ch
// Description : One pushbutton channel. It runs a metastability synchronizer,
//               then a debounce FSM with a stable-sample counter, and
//               registers the level, press and release outputs.
//               Optional auto-repeat is built in when BTN_AUTOREPEAT_EN is
//               defined.
// Ports       : clk         - system clock, rising edge
//               rst         - synchronous active-high reset
//               i_btn_raw   - raw asynchronous button level
//               o_level     - debounced level
//               o_press     - one-cycle pulse per accepted press (and repeat)
//               o_release   - one-cycle pulse per accepted release
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce_ch
    import tictactoe_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DEB_MAX = c_CNT_W'(DEBOUNCE_CYCLES);

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    btn_state_t         r_state;
    btn_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_stable_done;
    logic               r_level;
    logic               w_level_nxt;
    logic               r_press;
    logic               w_press_nxt;
    logic               w_press_all;
    logic               r_release;
    logic               w_release_nxt;

    // The counter rests at zero in IDLE_LO/HELD_HI, so w_cnt_inc is the
    // number of consecutive differing samples including the current one.
    // That makes DEBOUNCE_CYCLES=1 accept straight from the settled states.
    assign w_cnt_inc     = r_cnt + c_CNT_W'(1);
    assign w_stable_done = (w_cnt_inc == c_DEB_MAX);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE_LO, WAIT_HI: begin
                if (!w_s) begin
                    w_state_nxt = IDLE_LO;
                    w_cnt_nxt   = '0;
                end else if (w_stable_done) begin
                    w_state_nxt = HELD_HI;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            HELD_HI, WAIT_LO: begin
                if (w_s) begin
                    // A bounce back high while releasing returns silently.
                    w_state_nxt = HELD_HI;
                    w_cnt_nxt   = '0;
                end else if (w_stable_done) begin
                    w_state_nxt   = IDLE_LO;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE_LO;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat: down-counter loaded on entry to HELD_HI, zero outside it.
    // ------------------------------------------------------------------
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    logic [c_REP_W-1:0] r_rep;
    logic [c_REP_W-1:0] w_rep_nxt;
    logic               w_rep_press;

    always_comb begin
        w_rep_nxt   = '0;
        w_rep_press = 1'b0;
        if (REPEAT_EN && (w_state_nxt == HELD_HI)) begin
            if (r_state != HELD_HI) begin
                w_rep_nxt = c_REP_W'(REPEAT_DELAY - 1);
            end else if (r_rep == '0) begin
                w_rep_press = 1'b1;
                w_rep_nxt   = c_REP_W'(REPEAT_PERIOD - 1);
            end else begin
                w_rep_nxt = r_rep - c_REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep <= '0;
        end else begin
            r_rep <= w_rep_nxt;
        end
    end

    assign w_press_all = w_press_nxt | w_rep_press;
`else
    assign w_press_all = w_press_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE_LO;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_all;
            r_release <= w_release_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule : btn_debounce_ch

`default_nettype wire

// File: rtl/move_button_conditioner.sv
// ============================================================================
// Module      : move_button_conditioner
// Description : Front end for the TicTacToe game core. It synchronizes and
//               debounces NUM_BTN raw pushbuttons and produces a debounced
//               level plus one-cycle press/release pulses per button.
//               Define BTN_AUTOREPEAT_EN to enable auto-repeat press pulses
//               on channels selected by REPEAT_MASK.
// Ports       : clk         - system clock, rising edge
//               rst         - synchronous active-high reset
//               btn_raw     - raw asynchronous button levels, active-high
//               btn_level   - debounced levels
//               btn_press   - one-cycle press pulses
//               btn_release - one-cycle release pulses
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_button_conditioner
    import tictactoe_pkg::*;
#(
    parameter int                 NUM_BTN         = 2,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter int                 REPEAT_DELAY    = 25000000,
    parameter int                 REPEAT_PERIOD   = 5000000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(2'b10)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    // Reject configurations the channel logic cannot implement.
    if (NUM_BTN < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || $bits(REPEAT_MASK) != NUM_BTN) begin : g_bad_params
        $error("move_button_conditioner: illegal parameter combination");
    end

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[gi])
`endif
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_btn_raw (btn_raw[gi]),
            .o_level   (btn_level[gi]),
            .o_press   (btn_press[gi]),
            .o_release (btn_release[gi])
        );
    end

endmodule : move_button_conditioner

`default_nettype wire
